// File: rtl/jk_pattern_driver_if.sv
// jk_pattern_driver_if: pattern handshake, j/k drive and q feedback between a
// pattern source / flip-flop side (master) and the jk_pattern_driver (slave).
interface jk_pattern_driver_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pattern;
    logic             j;
    logic             k;
    logic             q;
    logic             busy;
    logic             done;
    logic             mismatch;

    // Source side: offers patterns and returns the flip-flop output.
    modport master (
        output in_valid, in_pattern, q,
        input  in_ready, j, k, busy, done, mismatch
    );

    // Driver side.
    modport slave (
        input  in_valid, in_pattern, q,
        output in_ready, j, k, busy, done, mismatch
    );
endinterface

// File: rtl/jk_pattern_driver.sv
// jk_pattern_driver: replays a WIDTH-bit pattern (bit 0 first) onto a JK
// flip-flop by encoding each desired next-q bit into registered j/k drives.
// Sequence per pattern: SYNC (force q=0), WIDTH DRIVE cycles, one DRAIN cycle,
// then a one-cycle done pulse back in IDLE.
// Optional q feedback checking is compiled in when JK_DRV_FEEDBACK_CHECK_EN
// is defined; otherwise mismatch is tied low and q is ignored.
module jk_pattern_driver #(
    parameter int WIDTH      = 8,
    parameter bit TOGGLE_ENC = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    jk_pattern_driver_if.slave bus
);
    localparam int            IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DRIVE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IW-1:0]    idx_q, idx_d, idx_nxt;
    logic             model_q, model_d;   // q value the flip-flop should hold now
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             done_q, done_d;
    logic             accept;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("jk_pattern_driver: WIDTH must be in 2..32");
    end

    // Excitation for moving q from cur to want: hold if equal, otherwise
    // toggle (j=k=1) or explicit set/reset depending on TOGGLE_ENC.
    function automatic logic [1:0] enc(input logic want, input logic cur);
        logic [1:0] jk;
        if (want == cur) begin
            jk = 2'b00;
        end else if (TOGGLE_ENC) begin
            jk = 2'b11;
        end else begin
            jk = {want, ~want};
        end
        return jk;
    endfunction

    assign accept  = (state_q == IDLE) && bus.in_valid;
    assign idx_nxt = idx_q + 1'b1;

    // Next-state and next j/k: j/k are computed for the phase being entered
    // so the registered drive lines up with the state it belongs to.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        model_d = model_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SYNC;
                    pat_d   = bus.in_pattern;
                    model_d = 1'b0;
                    k_d     = 1'b1;          // reset the flip-flop to a known 0
                end
            end
            SYNC: begin
                state_d    = DRIVE;
                idx_d      = '0;
                {j_d, k_d} = enc(pat_q[0], model_q);
            end
            DRIVE: begin
                model_d = pat_q[idx_q];      // this bit is in q after this edge
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d      = idx_nxt;
                    {j_d, k_d} = enc(pat_q[idx_nxt], pat_q[idx_q]);
                end
            end
            DRAIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    // State and drive registers; reset aborts any replay without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            model_q <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            model_q <= model_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

`ifdef JK_DRV_FEEDBACK_CHECK_EN
    logic mismatch_q, mismatch_d;
    logic chk_pt;

    // q is settled to model_q throughout DRIVE and DRAIN; the SYNC cycle is
    // skipped because the flip-flop state is unknown until it is forced low.
    assign chk_pt = (state_q == DRIVE) || (state_q == DRAIN);

    // Sticky miscompare flag, cleared by a new accept.
    always_comb begin
        mismatch_d = mismatch_q;
        if (accept) begin
            mismatch_d = 1'b0;
        end else if (chk_pt && (bus.q != model_q)) begin
            mismatch_d = 1'b1;
        end
    end

    // Mismatch register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.mismatch = mismatch_q;
`else
    logic unused_q;
    assign unused_q     = bus.q;
    assign bus.mismatch = 1'b0;
`endif

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.j        = j_q;
    assign bus.k        = k_q;
    assign bus.done     = done_q;

    // Set/reset encoding must never request a toggle.
    a_no_toggle: assert property (@(posedge clk) disable iff (rst)
        !(!TOGGLE_ENC && j_q && k_q));

    // Done only ever follows the drain cycle.
    a_done_after_drain: assert property (@(posedge clk) disable iff (rst)
        done_d |-> (state_q == DRAIN));
endmodule
